// File: rtl/pc_stack_if.sv
// pc_stack_if: command and status bundle between the fetch controller and pc_stack
interface pc_stack_if #(
  parameter int W     = 8,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH) + 1;
  logic           ID_rst;
  logic           stall;
  logic           jmp;
  logic [W-1:0]   jmp_addr;
  logic           rel;
  logic [7:0]     rel_off;
  logic           call;
  logic           ret;
  logic           reti;
  logic           int_take;
  logic [W-1:0]   int_vec;
  logic [W-1:0]   PC_count;
  logic [SPW-1:0] sp_level;
  logic           stack_full;
  logic           stack_empty;
  logic           stack_ovf;
  logic           stack_unf;
  modport master (
    output ID_rst, stall, jmp, jmp_addr, rel, rel_off, call, ret, reti, int_take, int_vec,
    input  PC_count, sp_level, stack_full, stack_empty, stack_ovf, stack_unf
  );
  modport slave (
    input  ID_rst, stall, jmp, jmp_addr, rel, rel_off, call, ret, reti, int_take, int_vec,
    output PC_count, sp_level, stack_full, stack_empty, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter with internal return-address stack; PC_STACK_TRAP_EN sends stack faults to TRAP_ADDR
module pc_stack #(
  parameter int           W         = 8,
  parameter int           DEPTH     = 8,
  parameter logic [W-1:0] TRAP_ADDR = '0
) (
  input logic        clk,
  input logic        rst,
  pc_stack_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam int XW  = (W > 8) ? W : 8;
  logic [W-1:0]   pc_q, pc_d, pc_nom, inc, top, rel_pc;
  logic [XW-1:0]  rel_sum;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           clr, full, empty;
  logic           do_int, do_reti, do_ret, do_call;
  logic           push, pop, push_ok, pop_ok, fault;
  assign clr = rst | bus.ID_rst;
  // command decode: a stalled cycle issues no stack operation at all
  always_comb begin
    full    = sp_q == SPW'(DEPTH);
    empty   = sp_q == '0;
    do_int  = !bus.stall && bus.int_take;
    do_reti = !bus.stall && !bus.int_take && bus.reti;
    do_ret  = !bus.stall && !bus.int_take && !bus.reti && bus.ret;
    do_call = !bus.stall && !bus.int_take && !bus.reti && !bus.ret && bus.call;
    push    = do_int | do_call;
    pop     = do_reti | do_ret;
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    fault   = (push && full) || (pop && empty);
  end
  // next PC: priority chain, faulting pops fall through to increment
  always_comb begin
    inc     = pc_q + W'(1);
    top     = mem_q[AW'(sp_q - SPW'(1))];
    rel_sum = XW'(pc_q) + XW'($signed(bus.rel_off));
    rel_pc  = rel_sum[W-1:0];
    pc_nom  = do_int   ? bus.int_vec :
              do_reti  ? (empty ? inc : top) :
              do_ret   ? (empty ? inc : top + W'(1)) :
              do_call  ? bus.jmp_addr :
              bus.jmp  ? bus.jmp_addr :
              bus.rel  ? rel_pc : inc;
`ifdef PC_STACK_TRAP_EN
    pc_d    = bus.stall ? pc_q : fault ? TRAP_ADDR : pc_nom;
`else
    pc_d    = bus.stall ? pc_q : pc_nom;
`endif
  end
`ifndef PC_STACK_TRAP_EN
  logic unused_trap;
  assign unused_trap = ^TRAP_ADDR;
`endif
  // stack pointer and sticky fault flags
  always_comb begin
    sp_d  = push_ok ? sp_q + SPW'(1) : pop_ok ? sp_q - SPW'(1) : sp_q;
    ovf_d = ovf_q | (push && full);
    unf_d = unf_q | (pop && empty);
  end
  // PC, pointer and flag registers
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // return-address storage, written only by a push that fits
  always_ff @(posedge clk) begin
    if (!clr && push_ok) mem_q[AW'(sp_q)] <= pc_q;
  end
  assign bus.PC_count    = pc_q;
  assign bus.sp_level    = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scoreboard bench for pc_stack at W=8, DEPTH=4
module tb_pc_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;
  exp_t sbq[$];
`ifdef PC_STACK_TRAP_EN
  localparam logic [7:0] OVF_PC = 8'h00;
  localparam logic [7:0] UNF_PC = 8'h00;
`else
  localparam logic [7:0] OVF_PC = 8'h64;
  localparam logic [7:0] UNF_PC = 8'h03;
`endif
  pc_stack_if #(.W(8), .DEPTH(4)) bus();
  pc_stack #(.W(8), .DEPTH(4), .TRAP_ADDR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic idle();
    bus.ID_rst   = 1'b0;
    bus.stall    = 1'b0;
    bus.jmp      = 1'b0;
    bus.jmp_addr = 8'h00;
    bus.rel      = 1'b0;
    bus.rel_off  = 8'h00;
    bus.call     = 1'b0;
    bus.ret      = 1'b0;
    bus.reti     = 1'b0;
    bus.int_take = 1'b0;
    bus.int_vec  = 8'h00;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] pc, input logic [2:0] sp,
                      input logic ovf, input logic unf);
    exp_t e;
    e.tag = tag;
    e.pc  = pc;
    e.sp  = sp;
    e.ovf = ovf;
    e.unf = unf;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".pc"},    bus.PC_count, e.pc);
    chk({e.tag, ".sp"},    {5'b0, bus.sp_level}, {5'b0, e.sp});
    chk({e.tag, ".ovf"},   {7'b0, bus.stack_ovf}, {7'b0, e.ovf});
    chk({e.tag, ".unf"},   {7'b0, bus.stack_unf}, {7'b0, e.unf});
    chk({e.tag, ".full"},  {7'b0, bus.stack_full}, {7'b0, e.sp == 3'd4});
    chk({e.tag, ".empty"}, {7'b0, bus.stack_empty}, {7'b0, e.sp == 3'd0});
    idle();
  endtask
  initial begin
    idle();
    rst = 1'b1;
    step("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) step("free", 8'(i), 3'd0, 1'b0, 1'b0);
    bus.jmp = 1'b1; bus.jmp_addr = 8'h10;
    step("jmp10", 8'h10, 3'd0, 1'b0, 1'b0);
    bus.call = 1'b1; bus.jmp_addr = 8'h40;
    step("call40", 8'h40, 3'd1, 1'b0, 1'b0);
    step("sub41", 8'h41, 3'd1, 1'b0, 1'b0);
    step("sub42", 8'h42, 3'd1, 1'b0, 1'b0);
    bus.ret = 1'b1;
    step("ret", 8'h11, 3'd0, 1'b0, 1'b0);
    bus.jmp = 1'b1; bus.jmp_addr = 8'h20;
    step("jmp20", 8'h20, 3'd0, 1'b0, 1'b0);
    bus.int_take = 1'b1; bus.int_vec = 8'h80; bus.jmp = 1'b1; bus.jmp_addr = 8'h55;
    step("int80", 8'h80, 3'd1, 1'b0, 1'b0);
    step("isr81", 8'h81, 3'd1, 1'b0, 1'b0);
    bus.reti = 1'b1;
    step("reti", 8'h20, 3'd0, 1'b0, 1'b0);
    step("post_reti", 8'h21, 3'd0, 1'b0, 1'b0);
    bus.jmp = 1'b1; bus.jmp_addr = 8'h30;
    step("jmp30", 8'h30, 3'd0, 1'b0, 1'b0);
    bus.rel = 1'b1; bus.rel_off = 8'hFC;
    step("rel_neg", 8'h2C, 3'd0, 1'b0, 1'b0);
    bus.rel = 1'b1; bus.rel_off = 8'h05;
    step("rel_pos", 8'h31, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1; bus.call = 1'b1; bus.jmp_addr = 8'h99;
      step("stall", 8'h31, 3'd0, 1'b0, 1'b0);
    end
    step("unstall", 8'h32, 3'd0, 1'b0, 1'b0);
    bus.jmp = 1'b1; bus.jmp_addr = 8'hFE;
    step("jmpFE", 8'hFE, 3'd0, 1'b0, 1'b0);
    step("incFF", 8'hFF, 3'd0, 1'b0, 1'b0);
    step("wrap", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.call = 1'b1; bus.jmp_addr = 8'h50;
    step("call50", 8'h50, 3'd1, 1'b0, 1'b0);
    bus.call = 1'b1; bus.ret = 1'b1; bus.jmp_addr = 8'h70;
    step("ret_wins", 8'h01, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.call = 1'b1; bus.jmp_addr = 8'h60 + 8'(i);
      step("nest", 8'h60 + 8'(i), 3'(i + 1), 1'b0, 1'b0);
    end
    bus.call = 1'b1; bus.jmp_addr = 8'h64;
    step("ovf", OVF_PC, 3'd4, 1'b1, 1'b0);
    bus.ret = 1'b1;
    step("unwind3", 8'h63, 3'd3, 1'b1, 1'b0);
    bus.ret = 1'b1;
    step("unwind2", 8'h62, 3'd2, 1'b1, 1'b0);
    bus.ret = 1'b1;
    step("unwind1", 8'h61, 3'd1, 1'b1, 1'b0);
    bus.ret = 1'b1;
    step("unwind0", 8'h02, 3'd0, 1'b1, 1'b0);
    bus.ret = 1'b1;
    step("unf", UNF_PC, 3'd0, 1'b1, 1'b1);
    step("sticky", UNF_PC + 8'h01, 3'd0, 1'b1, 1'b1);
    bus.ID_rst = 1'b1; bus.call = 1'b1; bus.jmp_addr = 8'h77;
    step("id_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    step("post_id_rst", 8'h01, 3'd0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with an integrated return-address stack.
- Supports absolute and relative jumps, CALL/RET/RETI, interrupt entry, fetch stall and soft flush.
- Sits at the head of the fetch stage and drives the program-memory address.
- Replaces the external stack path used by the 8-bit PC; the return address is held internally.

Parameters:
W, 8, PC / address width in bits
DEPTH, 8, return-stack entries (power of 2, >=2)
TRAP_ADDR, 0, PC load value on stack fault (used only with PC_STACK_TRAP_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ID_rst  in  1  soft reset from decoder, same effect as rst
stall  in  1  hold PC and stack for this cycle
jmp  in  1  absolute jump to jmp_addr
jmp_addr  in  W  absolute target
rel  in  1  relative branch: PC_count + sign-extended rel_off
rel_off  in  8  signed two's-complement offset
call  in  1  push PC_count, load jmp_addr
ret  in  1  pop, load top+1
reti  in  1  pop, load top (no +1)
int_take  in  1  interrupt entry: push PC_count, load int_vec
int_vec  in  W  interrupt vector
PC_count  out  W  current program address
sp_level  out  $clog2(DEPTH)+1  number of stack entries in use
stack_full  out  1  sp_level==DEPTH
stack_empty  out  1  sp_level==0
stack_ovf  out  1  sticky: push attempted while full
stack_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst or ID_rst, sampled at the clock edge): PC_count=0, sp_level=0, stack_ovf=0, stack_unf=0. Stack RAM contents are don't-care.
- All updates are registered; a new PC appears the cycle after the command.
- Priority per cycle: reset > stall > int_take > reti > ret > call > jmp > rel > increment.
- Only the highest-priority command acts; lower ones are ignored.
- stall=1: PC, stack, sp_level and flags are all held.
- Increment: PC_count <= PC_count+1, modulo 2^W (wraps at all-ones to 0).
- int_take: mem[sp] <= PC_count, sp++, PC <= int_vec. The interrupted instruction is re-fetched on RETI.
- call: mem[sp] <= PC_count, sp++, PC <= jmp_addr.
- ret: sp--, PC <= mem[sp-1]+1, modulo 2^W.
- reti: sp--, PC <= mem[sp-1].
- jmp: PC <= jmp_addr.
- rel: PC <= PC_count + sign-extended rel_off, modulo 2^W. For W<8, the result is truncated to W bits.
- Push when full (call or int_take):
  - no write, sp unchanged, stack_ovf <= 1;
  - PC still loads the target (default build).
- Pop when empty (ret or reti):
  - sp unchanged, stack_unf <= 1;
  - PC <= PC_count+1 (default build).
- Flags are sticky and clear only on reset.
- Stack storage: DEPTH x W register array, written only on a successful push. The top is readable combinationally for the pop path.
- stack_full and stack_empty are combinational from sp_level.
- reset and ID_rst asserted mid-sequence discard any push or pop in that cycle.

Optional Feature:
Macro PC_STACK_TRAP_EN.
- Defined: any overflow or underflow event loads PC <= TRAP_ADDR instead of the default target. Flags are set as normal. A faulting push still writes nothing.
- Undefined: default fault behaviour as described in Behaviour; the TRAP_ADDR parameter is unused.

Test Plan:
- Reset then 5 free cycles -> PC_count = 0,1,2,3,4,5; at W=8, reaching 0xFF then the next cycle -> 0x00.
- PC=0x10, call jmp_addr=0x40; run to 0x42, then ret -> PC=0x40,0x41,0x42,0x11; sp_level 0->1->0.
- PC=0x20, int_take int_vec=0x80; later reti -> PC=0x80 then back to 0x20, exact, no +1.
- PC=0x30, rel rel_off=0xFC -> 0x2C; then rel_off=0x05 -> 0x31. Stall held 3 cycles -> PC frozen at 0x31, then 0x32.
- DEPTH=4: 5 nested calls -> 5th sets stack_ovf=1 and sp_level stays 4. ret on empty stack -> stack_unf=1, PC+1 (default) or TRAP_ADDR (PC_STACK_TRAP_EN).
- call+ret in the same cycle -> ret wins. ID_rst during call -> PC=0, sp_level=0.
